uart_rx: RTL

- UART receiver: oversamples the asynchronous `rxd` line, recovers 8N1 frames (LSB first) and presents each byte on an AXI Stream source.
- Mirror of the UART transmit peripheral. Sits between the board RX pin and a downstream queue/consumer on the same clock.
- Flags framing and overrun errors as single-cycle pulses.

---
 rtl/uart_rx_if.sv | 17 +
 rtl/uart_rx.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : axis_interface
// Description : Minimal AXI Stream bundle (tdata/tvalid/tready).
// Revision    : 1.0 - initial release
// ============================================================================
interface axis_interface #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport Source (output tdata, output tvalid, input tready);
    modport Sink   (input tdata, input tvalid, output tready);
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : Oversampling 8N1 UART receiver with AXI Stream byte output,
//               framing-error and overrun-error pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rxd,
    axis_interface.Source        stream,
    output logic                 framing_error,
    output logic                 overrun_error,
    output logic                 busy
);

    localparam int              c_cnt_w = $clog2(CLKS_PER_BIT);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0] c_half = c_cnt_w'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_cnt_next;
    logic [2:0]           r_bit;
    logic [2:0]           w_bit_next;
    logic [7:0]           r_shift;
    logic                 r_rxd_meta;
    logic                 r_rxd_s;
    logic                 r_tvalid;
    logic [7:0]           r_tdata;
    logic                 r_framing_error;
    logic                 r_overrun_error;
    logic                 w_sample;
    logic                 w_complete;
    logic                 w_frame_err;
    logic                 w_accept;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt + 1'b1;
        w_bit_next   = r_bit;
        w_sample     = 1'b0;
        w_complete   = 1'b0;
        w_frame_err  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_next = '0;
                w_bit_next = 3'd0;
                if (!r_rxd_s) w_state_next = S_START;
            end
            S_START: begin
                // Mid-start-bit check rejects short glitches silently.
                if (r_cnt == c_half) begin
                    w_cnt_next   = '0;
                    w_state_next = r_rxd_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_cnt == c_last) begin
                    w_cnt_next = '0;
                    w_sample   = 1'b1;
                    if (r_bit == 3'd7) begin
                        w_bit_next   = 3'd0;
                        w_state_next = S_STOP;
                    end else begin
                        w_bit_next = r_bit + 3'd1;
                    end
                end
            end
            S_STOP: begin
                // Sampled mid-stop-bit, so IDLE re-arms half a bit early.
                if (r_cnt == c_last) begin
                    w_cnt_next = '0;
                    if (r_rxd_s) begin
                        w_complete   = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_frame_err  = 1'b1;
                        w_state_next = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                w_cnt_next = '0;
                if (r_rxd_s) w_state_next = S_IDLE;
            end
            default: begin
                w_cnt_next   = '0;
                w_bit_next   = 3'd0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign w_accept = r_tvalid && stream.tready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rxd_meta      <= 1'b1;
            r_rxd_s         <= 1'b1;
            r_state         <= S_IDLE;
            r_cnt           <= '0;
            r_bit           <= 3'd0;
            r_shift         <= 8'd0;
            r_tvalid        <= 1'b0;
            r_tdata         <= 8'd0;
            r_framing_error <= 1'b0;
            r_overrun_error <= 1'b0;
        end else begin
            r_rxd_meta      <= rxd;
            r_rxd_s         <= r_rxd_meta;
            r_state         <= w_state_next;
            r_cnt           <= w_cnt_next;
            r_bit           <= w_bit_next;
            if (w_sample) r_shift[r_bit] <= r_rxd_s;
            r_framing_error <= w_frame_err;
            // Acceptance in the same cycle frees the slot before completion.
            r_overrun_error <= w_complete && r_tvalid && !stream.tready;
            if (w_complete && (!r_tvalid || w_accept)) begin
                r_tdata  <= r_shift;
                r_tvalid <= 1'b1;
            end else if (w_accept) begin
                r_tvalid <= 1'b0;
            end
        end
    end

    assign stream.tdata   = r_tdata;
    assign stream.tvalid  = r_tvalid;
    assign framing_error  = r_framing_error;
    assign overrun_error  = r_overrun_error;
    assign busy           = (r_state != S_IDLE);

endmodule
`default_nettype wire
